// File: rtl/id_stage_pkg.sv
// Shared MIPS decode constants for the ID stage: opcodes, R-type functs and fixed GPR indices.
package id_stage_pkg;

  localparam logic [5:0] OpRtype  = 6'h00;
  localparam logic [5:0] OpRegimm = 6'h01;
  localparam logic [5:0] OpJ      = 6'h02;
  localparam logic [5:0] OpJal    = 6'h03;
  localparam logic [5:0] OpBeq    = 6'h04;
  localparam logic [5:0] OpBne    = 6'h05;
  localparam logic [5:0] OpAddi   = 6'h08;
  localparam logic [5:0] OpAddiu  = 6'h09;
  localparam logic [5:0] OpSlti   = 6'h0A;
  localparam logic [5:0] OpSltiu  = 6'h0B;
  localparam logic [5:0] OpAndi   = 6'h0C;
  localparam logic [5:0] OpOri    = 6'h0D;
  localparam logic [5:0] OpXori   = 6'h0E;
  localparam logic [5:0] OpLui    = 6'h0F;
  localparam logic [5:0] OpLw     = 6'h23;
  localparam logic [5:0] OpSw     = 6'h2B;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;
  localparam logic [5:0] FnAdd   = 6'h20;

  localparam logic [4:0] RegZero = 5'd0;
  localparam logic [4:0] RegSp   = 5'd29;
  localparam logic [4:0] RegRa   = 5'd31;

  // R-type ops whose result lands in HI/LO or nowhere do not write a GPR.
  function automatic logic rtype_writes(logic [5:0] funct);
    case (funct)
      FnJr, FnMthi, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu: return 1'b0;
      default:                                             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 GPR file: two combinational read ports, one write port, $0 hard-wired to zero.
module regfile
  import id_stage_pkg::*;
#(
  parameter logic [31:0] SpReset = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];

  always_comb begin
    gpr_d = gpr_q;
    if (we_i && (waddr_i != RegZero)) begin
      gpr_d[waddr_i] = wdata_i;
    end
    gpr_d[0] = '0;
  end

  // Async reset also blocks writes for as long as rst_i is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= (i == int'(RegSp)) ? SpReset : 32'h0;
      end
    end else begin
      gpr_q <= gpr_d;
    end
  end

  assign rdata1_o = (raddr1_i == RegZero) ? 32'h0 : gpr_q[raddr1_i];
  assign rdata2_o = (raddr2_i == RegZero) ? 32'h0 : gpr_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: operand routing, immediate extension, write-back.
// Optional feature: define ID_WCOUNT_EN to add the WCount committed-write counter output.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPC,
  input  logic [31:0] Result,
  input  logic [31:0] MemData,
  output logic [31:0] Rdata1,
  output logic [31:0] Rdata2,
  output logic [31:0] Ed32,
  output logic        RegWrite,
  output logic [4:0]  Waddr
`ifdef ID_WCOUNT_EN
  ,
  output logic [31:0] WCount
`endif
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] rs_val, rt_val, wdata;
  logic        commit;

  assign opcode = Ins[31:26];
  assign rs     = Ins[25:21];
  assign rt     = Ins[20:16];
  assign rd     = Ins[15:11];
  assign shamt  = Ins[10:6];
  assign funct  = Ins[5:0];
  assign imm16  = Ins[15:0];

  always_comb begin
    Rdata1   = rt_val;
    Rdata2   = rs_val;
    Ed32     = {{16{imm16[15]}}, imm16};
    RegWrite = 1'b0;
    Waddr    = rt;
    wdata    = Result;
    unique case (opcode)
      OpRtype: begin
        Waddr    = rd;
        RegWrite = rtype_writes(funct);
        case (funct)
          FnSll, FnSrl, FnSra:    Rdata2 = {27'b0, shamt};
          FnSllv, FnSrlv, FnSrav: Rdata2 = {27'b0, rs_val[4:0]};
          default: begin
            Rdata1 = rs_val;
            Rdata2 = rt_val;
          end
        endcase
      end
      OpRegimm: Rdata1 = {27'b0, rt};
      OpJal: begin
        RegWrite = 1'b1;
        Waddr    = RegRa;
        wdata    = nextPC;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu: RegWrite = 1'b1;
      OpAndi, OpOri, OpXori: begin
        RegWrite = 1'b1;
        Ed32     = {16'h0, imm16};
      end
      OpLw: begin
        RegWrite = 1'b1;
        wdata    = MemData;
      end
      default: ;
    endcase
  end

  assign commit = RegWrite && (Waddr != RegZero);

  regfile #(
    .SpReset (SP_RESET)
  ) u_regfile (
    .clk_i    (CLK),
    .rst_i    (RST),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val),
    .we_i     (commit),
    .waddr_i  (Waddr),
    .wdata_i  (wdata)
  );

`ifdef ID_WCOUNT_EN
  logic [31:0] wcount_q, wcount_d;

  always_comb begin
    wcount_d = wcount_q;
    if (commit) begin
      wcount_d = wcount_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcount_q <= '0;
    end else begin
      wcount_q <= wcount_d;
    end
  end

  assign WCount = wcount_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expectations, a monitor pops and compares.
module tb_id_stage;

  localparam logic [31:0] Sp = 32'h7FFF_EFFC;

  logic        CLK, RST;
  logic [31:0] Ins, nextPC, Result, MemData;
  logic [31:0] Rdata1, Rdata2, Ed32;
  logic        RegWrite;
  logic [4:0]  Waddr;
`ifdef ID_WCOUNT_EN
  logic [31:0] WCount;
`endif

  id_stage #(
    .SP_RESET (Sp)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Ins      (Ins),
    .nextPC   (nextPC),
    .Result   (Result),
    .MemData  (MemData),
    .Rdata1   (Rdata1),
    .Rdata2   (Rdata2),
    .Ed32     (Ed32),
    .RegWrite (RegWrite),
    .Waddr    (Waddr)
`ifdef ID_WCOUNT_EN
    ,
    .WCount   (WCount)
`endif
  );

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ed;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wc;
  } exp_t;

  exp_t        exp_q [$];
  string       name_q [$];
  logic        sample;
  int          n_vec;
  int          n_err;
  logic [31:0] exp_wc;

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic expect_vec(string name, logic [31:0] r1, logic [31:0] r2, logic [31:0] ed,
                            logic rw, logic [4:0] wa);
    exp_t e;
    #1;
    e.r1 = r1; e.r2 = r2; e.ed = ed; e.rw = rw; e.wa = wa; e.wc = exp_wc;
    exp_q.push_back(e);
    name_q.push_back(name);
    sample = 1'b1;
    #1;
    sample = 1'b0;
    #1;
  endtask

  task automatic tick(bit commits);
    #2 CLK = 1'b1;
    if (commits) exp_wc = exp_wc + 32'd1;
    #3 CLK = 1'b0;
    #2;
  endtask

  // Monitor: whenever the driver strobes, compare the DUT outputs against the oldest expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge sample);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: strobe with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (Rdata1 !== e.r1 || Rdata2 !== e.r2 || Ed32 !== e.ed || RegWrite !== e.rw ||
            Waddr !== e.wa
`ifdef ID_WCOUNT_EN
            || WCount !== e.wc
`endif
            ) begin
          n_err++;
          $display("FAIL %s: got r1=%h r2=%h ed=%h rw=%b wa=%0d, want r1=%h r2=%h ed=%h rw=%b wa=%0d",
                   nm, Rdata1, Rdata2, Ed32, RegWrite, Waddr, e.r1, e.r2, e.ed, e.rw, e.wa);
`ifdef ID_WCOUNT_EN
          $display("  %s: wcount got %h want %h", nm, WCount, e.wc);
`endif
        end
      end
    end
  end

  initial begin
    CLK = 1'b0; RST = 1'b0; sample = 1'b0;
    n_vec = 0; n_err = 0; exp_wc = '0;
    Ins = '0; nextPC = '0; Result = '0; MemData = '0;

    // Asynchronous reset pulse with no clock edge.
    #3 RST = 1'b1;
    #2 RST = 1'b0;
    Ins = r_ins(5'd29, 5'd5, 5'd1, 5'd0, 6'h20);
    expect_vec("reset_sp", Sp, 32'h0, 32'h0000_0820, 1'b1, 5'd1);

    // ADDI $8,$0,-4: same-cycle read of $8 still old, then commit.
    Ins = i_ins(6'h08, 5'd0, 5'd8, 16'hFFFC); Result = 32'hFFFF_FFFC;
    expect_vec("addi_neg", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 5'd8);
    tick(1);

    Ins = r_ins(5'd8, 5'd0, 5'd10, 5'd0, 6'h20); Result = 32'h11;
    expect_vec("rtype_rs8", 32'hFFFF_FFFC, 32'h0, 32'h0000_5020, 1'b1, 5'd10);
    tick(1);

    Ins = r_ins(5'd10, 5'd0, 5'd0, 5'd0, 6'h20); Result = 32'h1234;
    expect_vec("add_to_r0", 32'h11, 32'h0, 32'h0000_0020, 1'b1, 5'd0);
    tick(0);

    Ins = r_ins(5'd0, 5'd10, 5'd2, 5'd0, 6'h20);
    expect_vec("r0_still_zero", 32'h0, 32'h11, 32'h0000_1020, 1'b1, 5'd2);

    Ins = i_ins(6'h08, 5'd0, 5'd4, 16'h0005); Result = 32'h5;
    expect_vec("addi_r4", 32'h0, 32'h0, 32'h5, 1'b1, 5'd4);
    tick(1);

    Ins = r_ins(5'd0, 5'd4, 5'd3, 5'd7, 6'h00);
    expect_vec("sll_route", 32'h5, 32'h7, 32'h0000_19C0, 1'b1, 5'd3);

    Ins = r_ins(5'd8, 5'd10, 5'd3, 5'd0, 6'h07);
    expect_vec("srav_route", 32'h11, 32'h1C, 32'h0000_1807, 1'b1, 5'd3);

    Ins = {6'h03, 26'h010_0004}; nextPC = 32'h0040_0010; Result = 32'hBAD;
    expect_vec("jal_decode", 32'h0, 32'h0, 32'h4, 1'b1, 5'd31);
    tick(1);

    Ins = r_ins(5'd31, 5'd29, 5'd5, 5'd0, 6'h25);
    expect_vec("read_ra", 32'h0040_0010, Sp, 32'h0000_2825, 1'b1, 5'd5);

    Ins = i_ins(6'h23, 5'd0, 5'd9, 16'h0010); MemData = 32'hDEAD_BEEF; Result = 32'h55;
    expect_vec("lw_decode", 32'h0, 32'h0, 32'h10, 1'b1, 5'd9);
    tick(1);

    Ins = i_ins(6'h2B, 5'd9, 5'd9, 16'hFFF0); Result = 32'h66;
    expect_vec("sw_no_write", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b0, 5'd9);
    tick(0);

    Ins = i_ins(6'h0D, 5'd0, 5'd6, 16'h8000); Result = 32'h8000;
    expect_vec("ori_zext", 32'h0, 32'h0, 32'h0000_8000, 1'b1, 5'd6);
    tick(1);

    Ins = i_ins(6'h01, 5'd6, 5'd17, 16'h8001); Result = 32'h99;
    expect_vec("regimm_rt", 32'h11, 32'h8000, 32'hFFFF_8001, 1'b0, 5'd17);
    tick(0);

    Ins = i_ins(6'h3F, 5'd9, 5'd17, 16'h7FFF); Result = 32'h77;
    expect_vec("unknown_op", 32'h0, 32'hDEAD_BEEF, 32'h0000_7FFF, 1'b0, 5'd17);
    tick(0);

    Ins = r_ins(5'd9, 5'd17, 5'd0, 5'd0, 6'h18);
    expect_vec("mult_after", 32'hDEAD_BEEF, 32'h0, 32'h0000_0018, 1'b0, 5'd0);

    Ins = i_ins(6'h0C, 5'd0, 5'd12, 16'hFFFF);
    expect_vec("andi_zext", 32'h0, 32'h0, 32'h0000_FFFF, 1'b1, 5'd12);

`ifdef ID_WCOUNT_EN
    force dut.wcount_q = 32'hFFFF_FFFF;
    #1 release dut.wcount_q;
    exp_wc = 32'hFFFF_FFFF;
    Ins = i_ins(6'h08, 5'd0, 5'd13, 16'h0001); Result = 32'h1;
    expect_vec("wcount_preload", 32'h0, 32'h0, 32'h1, 1'b1, 5'd13);
    tick(1);
    Ins = r_ins(5'd13, 5'd0, 5'd1, 5'd0, 6'h20);
    expect_vec("wcount_wrap", 32'h1, 32'h0, 32'h0000_0820, 1'b1, 5'd1);
`endif

    // Reset mid-stream with a writing instruction presented: no write lands.
    Ins = i_ins(6'h08, 5'd0, 5'd8, 16'h0077); Result = 32'h77;
    RST = 1'b1;
    tick(0);
    exp_wc = '0;
    #1 RST = 1'b0;
    Ins = r_ins(5'd8, 5'd29, 5'd1, 5'd0, 6'h20);
    expect_vec("rst_r8_cleared", 32'h0, Sp, 32'h0000_0820, 1'b1, 5'd1);

    Ins = r_ins(5'd31, 5'd9, 5'd1, 5'd0, 6'h20);
    expect_vec("rst_ra_r9_cleared", 32'h0, 32'h0, 32'h0000_0820, 1'b1, 5'd1);

    #10;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
